// File: rtl/mole_pkg.sv
// mole_pkg: shared state type, counter width and up-window helper for the mole scheduler
package mole_pkg;
  localparam int MS_W = 11;
  typedef enum logic [1:0] {IDLE, WAIT, UP} state_t;
  function automatic logic [MS_W-1:0] up_window(input logic [MS_W-1:0] up_ms, input logic [1:0] level);
    return up_ms >> level;
  endfunction
endpackage

// File: rtl/mole_scheduler_if.sv
// mole_scheduler_if: game-control inputs and LED/pulse outputs of the mole scheduler
interface mole_scheduler_if import mole_pkg::*; #(parameter int NUM_MOLES = 8);
  logic enable;
  logic [1:0] level;
  logic [MS_W-1:0] random_value;
  logic [NUM_MOLES-1:0] buttons;
  logic [NUM_MOLES-1:0] mole_leds;
  logic hit_pulse;
  logic miss_pulse;
  logic wrong_pulse;
  logic busy;
  modport master (
    output enable, level, random_value, buttons,
    input mole_leds, hit_pulse, miss_pulse, wrong_pulse, busy
  );
  modport slave (
    input enable, level, random_value, buttons,
    output mole_leds, hit_pulse, miss_pulse, wrong_pulse, busy
  );
endinterface

// File: rtl/ms_timer.sv
// ms_timer: prescaled millisecond down-counter with a one-cycle expire pulse
module ms_timer import mole_pkg::*; #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [MS_W-1:0] load_ms,
  output logic            expire
);
  localparam int PW = CLKS_PER_MS > 1 ? $clog2(CLKS_PER_MS) : 1;
  logic [PW-1:0] pre;
  logic [MS_W-1:0] ms;
  logic tick;
  assign tick = pre == PW'(CLKS_PER_MS - 1);
  // expire flags the last cycle of the final millisecond so the next edge lands exactly on the dwell
  assign expire = tick && ms == MS_W'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      ms  <= '0;
    end else if (load) begin
      pre <= '0;
      ms  <= load_ms;
    end else if (ms != '0) begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) ms <= ms - MS_W'(1);
    end
  end
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: idle-gap / mole-up FSM with hole selection, button edge detect and hit/miss reporting
module mole_scheduler import mole_pkg::*; #(
  parameter int CLKS_PER_MS = 50000,
  parameter int NUM_MOLES   = 8,
  parameter int UP_MS       = 1200
) (
  input logic clk,
  input logic rst,
  mole_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_MOLES);
  state_t state;
  logic [NUM_MOLES-1:0] buttons_q, press_q, leds;
  logic [IW-1:0] prev_idx, idx_raw, idx_n;
  logic [MS_W-1:0] gap, load_ms;
  logic hit, miss, wrong, busy, expire, load, hit_c;
  always_comb begin
    idx_raw = bus.random_value[IW-1:0];
    idx_n   = idx_raw == prev_idx ? idx_raw + IW'(1) : idx_raw;
    gap     = bus.random_value == '0 ? MS_W'(1) : bus.random_value;
    hit_c   = state == UP && press_q[prev_idx];
    load    = bus.enable && (state == IDLE || (state == WAIT && expire) || (state == UP && (hit_c || expire)));
    load_ms = state == WAIT ? up_window(MS_W'(UP_MS), bus.level) : gap;
  end
  ms_timer #(.CLKS_PER_MS(CLKS_PER_MS)) u_timer (
    .clk(clk), .rst(rst), .load(load), .load_ms(load_ms), .expire(expire)
  );
  // prev_idx doubles as the lit hole while UP; press_q is the registered rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      leds      <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      wrong     <= 1'b0;
      busy      <= 1'b0;
      buttons_q <= '0;
      press_q   <= '0;
      prev_idx  <= IW'(NUM_MOLES - 1);
    end else begin
      buttons_q <= bus.buttons;
      press_q   <= bus.buttons & ~buttons_q;
      hit       <= 1'b0;
      miss      <= 1'b0;
      wrong     <= 1'b0;
      if (!bus.enable) begin
        state <= IDLE;
        leds  <= '0;
        busy  <= 1'b0;
      end else if (state == IDLE) begin
        state <= WAIT;
        busy  <= 1'b1;
      end else if (state == WAIT) begin
        if (expire) begin
          state    <= UP;
          prev_idx <= idx_n;
          leds     <= NUM_MOLES'(1) << idx_n;
        end
      end else begin
        // a wrong press never masks the timeout, otherwise the window could never close
        wrong <= |(press_q & ~leds);
        if (hit_c || expire) begin
          state <= WAIT;
          leds  <= '0;
          hit   <= hit_c;
          miss  <= !hit_c;
        end
      end
    end
  end
  assign bus.mole_leds   = leds;
  assign bus.hit_pulse   = hit;
  assign bus.miss_pulse  = miss;
  assign bus.wrong_pulse = wrong;
  assign bus.busy        = busy;
endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game-timing stage fed by `rng_mole`. It uses each `random_value` as the idle gap in milliseconds before the next mole appears. It then picks which hole lights, holds the mole up for a level-dependent window, and reports a hit or a miss. Outputs drive the mole LEDs directly and feed the score/lives logic downstream.

## Interface
Clock `clk`; reset `rst`, asynchronous, active-high.

Parameters:
- `CLKS_PER_MS`, 50000: clock cycles per millisecond (50 MHz).
- `NUM_MOLES`, 8: holes/LEDs; power of two, 2..16.
- `UP_MS`, 1200: mole-up window at level 0, in ms.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: async active-high reset.
- `enable`  in  1: game running; low forces IDLE.
- `level`  in  2: difficulty 0..3.
- `random_value`  in  11: from `rng_mole`, changes every cycle.
- `buttons`  in  NUM_MOLES: debounced, synchronised button levels.
- `mole_leds`  out  NUM_MOLES: one-hot lit mole, else 0.
- `hit_pulse`  out  1: one-cycle pulse on correct hit.
- `miss_pulse`  out  1: one-cycle pulse on up-window timeout.
- `wrong_pulse`  out  1: one-cycle pulse on wrong button during UP.
- `busy`  out  1: high in WAIT or UP.

## Operation
- States:
  - IDLE → WAIT when `enable`=1.
  - WAIT → UP at gap expiry.
  - UP → WAIT on hit or timeout.
  - Any state → IDLE when `enable`=0 (priority over everything).
- WAIT entry:
  - `gap_ms = random_value` sampled that cycle; 0 is treated as 1.
  - Clear the prescaler.
  - `mole_leds`=0.
- UP entry:
  - `idx = random_value[log2(NUM_MOLES)-1:0]`, sampled that cycle.
  - If `idx` equals the previous index, use `idx+1` (mod NUM_MOLES).
  - Latch `level`; `up_ms = UP_MS >> level` (1200/600/300/150 by default).
  - Clear the prescaler.
  - `mole_leds` = one-hot(`idx`).
- Button edges: `buttons` is registered once; `press = buttons & ~buttons_q`. Only rising edges count; a button already held on UP entry does not count.
- In UP, each cycle:
  - `press[idx]` → `hit_pulse`, go to WAIT.
  - Otherwise, any other press bit → `wrong_pulse`, stay in UP.
  - Otherwise, `up_ms` expiry → `miss_pulse`, go to WAIT.
  - Hit wins over a simultaneous timeout. Both `hit_pulse` and `wrong_pulse` may assert together when multiple buttons rise in the same cycle as the correct one.
- Presses in IDLE or WAIT are ignored and produce no pulses.
- The previous index resets to NUM_MOLES-1, so the first mole may appear at any index except NUM_MOLES-1.
- The ms counter is 11 bits, which covers the full `random_value` range and `UP_MS` ≤ 2047. `UP_MS` > 2047 is illegal.

## Timing
- Reset values: state IDLE, `mole_leds`=0, all pulses 0, `busy`=0, prescaler 0, ms counter 0, `buttons_q`=0, previous index NUM_MOLES-1.
- All outputs are registered.
- `busy` rises 1 cycle after `enable` is sampled high.
- The WAIT dwell is exactly `gap_ms*CLKS_PER_MS` cycles. LEDs light on the following edge.
- The UP dwell before a miss is exactly `up_ms*CLKS_PER_MS` cycles. `miss_pulse` and LED clear occur on the same edge.
- Hit latency: a button rising before edge N is registered at N; `hit_pulse`, LED clear and WAIT entry take effect at edge N+1.
- `enable` low: IDLE on the next edge, LEDs clear, and no pulse is emitted for an aborted UP.
- Reset mid-UP: outputs clear immediately (asynchronously) and no pulse is emitted.
- A `level` change during UP does not affect the current window.

## Structure
- `mole_pkg`:
  - state enum {IDLE, WAIT, UP};
  - `MS_W`=11;
  - a function `up_window(up_ms, level)`.
- Sub-module `ms_timer`:
  - prescaler plus ms down-counter;
  - inputs `load`, `load_ms[10:0]`; output `expire` is a one-cycle pulse.
  - The scheduler FSM, index selection and edge detect live in `mole_scheduler`.

## Test plan
All scenarios use `CLKS_PER_MS`=4 and `UP_MS`=8.
- Reset, then `enable`=1, hold `random_value`=5 → `busy` after 1 cycle; LED lights after exactly 20 cycles in WAIT; LED at index 5 mod 8 = 5.
- Level 0 with no press → LED on for 32 cycles, then `miss_pulse` for 1 cycle and LEDs 0. Repeat at level 3 → 4 cycles.
- Mole at idx 2, `buttons`=0000_0100 rising → `hit_pulse` 2 edges later, LEDs 0, WAIT reloaded. A press on bit 3 instead → `wrong_pulse` only, LED stays lit.
- Correct press timed so its registered edge coincides with timeout → `hit_pulse`=1, `miss_pulse`=0.
- `random_value`=0 in WAIT → 4-cycle gap. Same low bits for two consecutive moles (e.g. 3 then 3) → second mole at idx 4.
- `enable` dropped mid-UP, and separately `rst` pulsed mid-WAIT → IDLE, LEDs 0, no pulses. Button held across UP entry → no hit.
